// File: rtl/exec_run_controller_pkg.sv
// exec_run_controller_pkg: run-state encoding shared by the run controller and the processor debug view.
package exec_run_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } run_state_e;

    function automatic logic is_enabled(input run_state_e s);
        return (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/exec_run_controller_btn_debounce.sv
// btn_debounce: two-flop synchronizer, stable-sample debounce counter and rising-edge press pulse.
module btn_debounce #(
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic        sync1_q, sync2_q;
    logic        db_q, db_d, db_prev_q;
    logic [15:0] cnt_q, cnt_d;

    // The debounced value follows the synced value only after DB_CYCLES consecutive mismatching samples.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == DB_CYCLES - 16'd1)
                db_d = sync2_q;
            else
                cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign press = db_q & ~db_prev_q;

endmodule

// File: rtl/exec_run_controller.sv
// exec_run_controller: sequences the core from the exec button via an IDLE/RUN/STEP/HALTED FSM,
// producing a registered clock-enable and a saturating count of enabled cycles.
module exec_run_controller
    import exec_run_controller_pkg::*;
#(
    parameter logic [15:0] DB_CYCLES = 16'd50000,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exec_btn,
    input  logic             step_mode,
    input  logic             halt,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic             press,
    output logic [CNT_W-1:0] cycle
);

    run_state_e       state_q, state_d;
    logic             cpu_en_q, running_q, halted_q;
    logic [CNT_W-1:0] cycle_q, cycle_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk   (clk),
        .reset (reset),
        .btn   (exec_btn),
        .press (press)
    );

    // Halt outranks any press; a press that lands while stepping is dropped.
    always_comb begin
        state_d = state_q;
        if (halt)
            state_d = HALTED;
        else
            case (state_q)
                IDLE:   if (press) state_d = step_mode ? STEP : RUN;
                RUN:    if (press) state_d = IDLE;
                STEP:   state_d = IDLE;
                HALTED: state_d = HALTED;
            endcase
        cycle_d = (cpu_en_q && cycle_q != '1) ? cycle_q + CNT_W'(1) : cycle_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            cycle_q   <= '0;
        end else begin
            state_q   <= state_d;
            cpu_en_q  <= is_enabled(state_d);
            running_q <= state_d == RUN;
            halted_q  <= state_d == HALTED;
            cycle_q   <= cycle_d;
        end
    end

    assign cpu_en  = cpu_en_q;
    assign running = running_q;
    assign halted  = halted_q;
    assign cycle   = cycle_q;

endmodule
